// File: rtl/decim_avg_block.sv
`default_nettype none
// ============================================================================
// Module      : decim_avg_block
// Description : Decimating averager. Takes a qualified stream of signed
//               samples from the two-input averaging adder. Every 2**LOG2_N
//               valid samples are averaged into one result. Arithmetic
//               truncation is toward minus infinity. Results are queued in a
//               show-ahead FIFO with a valid/ready handshake.
// Ports       : ip_clock    - clock, rising edge
//               ip_reset    - asynchronous reset, active low
//               ip_data     - signed input sample
//               ip_valid    - ip_data carries a new sample this cycle
//               ip_clear    - synchronous flush of accumulator, FIFO, overflow
//               ip_ready    - downstream accepts op_data this cycle
//               op_data     - FIFO head result (0 while op_valid is low)
//               op_valid    - FIFO holds at least one result
//               op_level    - FIFO occupancy
//               op_overflow - sticky: a result was dropped on a full FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module decim_avg_block #(
    parameter int DATA_W     = 12,
    parameter int LOG2_N     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          ip_clock,
    input  logic                          ip_reset,
    input  logic [DATA_W-1:0]             ip_data,
    input  logic                          ip_valid,
    input  logic                          ip_clear,
    input  logic                          ip_ready,
    output logic [DATA_W-1:0]             op_data,
    output logic                          op_valid,
    output logic [$clog2(FIFO_DEPTH):0]   op_level,
    output logic                          op_overflow
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LOG2_N-1:0] C_CNT_LAST = {LOG2_N{1'b1}};
    localparam logic [LVL_W-1:0]  C_FULL_LVL = LVL_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]  acc_q,      acc_d;
    logic [LOG2_N-1:0] cnt_q,      cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0]  count_q,    count_d;
    logic              overflow_q, overflow_d;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Accumulator datapath
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]  w_sample_ext;
    logic [ACC_W-1:0]  w_sum;
    logic [DATA_W-1:0] w_result;
    logic              w_last;

    // The accumulator is LOG2_N bits wider than a sample, so a full group of
    // sign-extended samples always fits without wrap-around.
    assign w_sample_ext = {{LOG2_N{ip_data[DATA_W-1]}}, ip_data};
    assign w_sum        = acc_q + w_sample_ext;
    // Dropping the LOG2_N LSBs of a two's-complement sum is an arithmetic
    // right shift, which floors the average (toward minus infinity).
    assign w_result     = w_sum[ACC_W-1 -: DATA_W];
    assign w_last       = (cnt_q == C_CNT_LAST);

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_wr_en;
    logic w_drop;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == C_FULL_LVL);
    // The clear input overrides both the push of a finishing group and the pop.
    assign w_push  = ip_valid & w_last & ~ip_clear;
    assign w_pop   = ~w_empty & ip_ready & ~ip_clear;
    // When full, the write lands in the slot being popped this same edge.
    // The read pointer advances past that slot, so the new result becomes
    // the tail.
    assign w_wr_en = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (ip_clear) begin
            acc_d      = '0;
            cnt_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (ip_valid) begin
                if (w_last) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = w_sum;
                    cnt_d = cnt_q + LOG2_N'(1);
                end
            end

            // The pointers are power-of-two sized, so they wrap naturally.
            if (w_wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            // Occupancy is tracked explicitly because a full FIFO and an
            // empty FIFO have the same pointer values.
            case ({w_wr_en, w_pop})
                2'b10:   count_d = count_q + LVL_W'(1);
                2'b01:   count_d = count_q - LVL_W'(1);
                default: count_d = count_q;
            endcase

            if (w_drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge ip_clock or negedge ip_reset) begin
        if (!ip_reset) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // The storage array needs no reset. Entries are only visible through
    // the occupancy count, and the count is reset.
    always_ff @(posedge ip_clock) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= w_result;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: derived from registered state only
    // ------------------------------------------------------------------
    assign op_valid    = ~w_empty;
    assign op_data     = w_empty ? '0 : mem_q[rd_ptr_q];
    assign op_level    = count_q;
    assign op_overflow = overflow_q;

endmodule
`default_nettype wire
